conbus_arb_quota: RTL and testbench
===================================

Name: conbus_arb_quota

Overview:
- Round-robin bus arbiter for the conbus interconnect, with a per-owner transaction quota.
- A master keeps the bus while it holds its request, but is preempted at a transaction boundary once it has completed MAX_HOLD transactions and another master is waiting.
- Prevents long DMA/burst masters (video, audio, FML bridges) from starving the CPU ports.
- Drives the conbus master mux select and per-master grant gating.

Parameters:
- NMASTERS, 5, number of requesting masters (2..8).
- GW, 3, width of the encoded grant; must satisfy 2**GW >= NMASTERS.
- MAX_HOLD, 16, transactions an owner may complete before it can be preempted; 0 disables preemption.
- CW, 5, width of the hold counter; must be able to hold MAX_HOLD.

Ports:
- sys_clk  input  1  system clock.
- sys_rst  input  1  synchronous active-high reset.
- req  input  NMASTERS  per-master bus request (cyc).
- txn_end  input  1  one-cycle pulse when the current owner's bus transaction completes (slave ack on the last beat).
- gnt  output  GW  encoded index of the current owner.
- gnt_oh  output  NMASTERS  one-hot form of gnt.
- gnt_chg  output  1  one-cycle pulse in the first cycle of a new grant.
- preempt  output  1  one-cycle pulse in the first cycle of a grant that was taken by quota preemption.

Behaviour:
- Clock and reset: single clock sys_clk; reset sys_rst is synchronous, active-high.
- Reset values: gnt=0, gnt_oh=1 (master 0), hold_cnt=0, gnt_chg=0, preempt=0.
- Outputs: all registered. A grant decision made in cycle N becomes visible in cycle N+1.
- Round-robin pick (sel): first requesting index scanning owner+1, owner+2, ..., wrapping modulo NMASTERS, with the owner checked last.
  - "others" = req with the owner's bit masked off.
- Next-state rules, evaluated each cycle in priority order:
  1. Release: req[owner]=0 and any req set -> owner := sel. gnt_chg=1 next cycle, preempt=0.
  2. Release with no requests: req[owner]=0 and req all zero -> grant parks on the current owner. No pulse.
  3. Preempt: req[owner]=1, txn_end=1, MAX_HOLD!=0, hold_cnt+1 >= MAX_HOLD, others!=0 -> owner := RR pick over others. gnt_chg=1 and preempt=1 next cycle.
  4. Otherwise: owner unchanged.
- Never switch while req[owner]=1 and txn_end=0. No mid-transaction break, ever.
- hold_cnt:
  - Cleared to 0 on any grant change.
  - Otherwise increments on txn_end while req[owner]=1.
  - Saturates at MAX_HOLD and never wraps.
  - With MAX_HOLD=0, hold_cnt stays 0.
- Quota met with no contenders: if hold_cnt reaches quota while others=0, the owner continues. It is preempted at the first later txn_end where others!=0, since the saturated counter still satisfies the condition.
- txn_end with req[owner]=0 in the same cycle: the release rule applies; the txn_end is ignored.
- Wrap-around: owner NMASTERS-1 scans 0, 1, ... next.
- Reset mid-operation: sys_rst overrides everything, so the grant returns to master 0 the cycle after reset is asserted. gnt_chg is not pulsed on reset.
- Output invariants: gnt_oh == (1 << gnt) always. gnt_chg and preempt are exactly one cycle wide. preempt implies gnt_chg.

Decomposition:
- Shared package conbus_pkg:
  - Localparam defaults for NMASTERS and GW.
  - Function clog2 for GW checking.
  - Enum for the next-state decision: KEEP, RELEASE, PREEMPT.
- Sub-module conbus_rr_pick:
  - Purely combinational rotate/priority-encode/rotate-back.
  - Inputs: request vector and start index.
  - Outputs: index and a found flag.
  - Instantiated twice: once on req (release path), once on others (preempt path).
- Parent holds the owner register, hold counter and pulse registers.

Test Plan:
- Reset, then req=5'b00000 for 10 cycles -> gnt=0, gnt_oh=00001, no gnt_chg.
- Owner 0 holding; req=5'b10110, then drop req[0] -> next cycle gnt=1. Next release -> gnt=2. Next release -> gnt=4, gnt_chg pulse each time, preempt=0.
- MAX_HOLD=4; master 2 holds req with txn_end every 3 cycles, req[3] rises after the 1st txn_end -> gnt switches to 3 the cycle after the 4th txn_end; preempt=1 for one cycle; hold_cnt=0.
- MAX_HOLD=4; master 1 alone for 10 txn_end; then req[0] rises between transactions -> no switch until the next txn_end, then gnt=0 with preempt=1.
- Master 4 owns; req[4]=1, txn_end=0, hold_cnt at quota, req[0]=1 for 20 cycles -> gnt stays 4 (no mid-transaction switch).
- Owner 3 with req=5'b01001 and sys_rst asserted for 1 cycle -> gnt=0 next cycle, hold_cnt=0, gnt_chg=0.

Source files
------------

// File: rtl/conbus_pkg.sv
// Shared definitions for the conbus arbiter: default sizes, width helper and
// the per-cycle grant decision type.
package conbus_pkg;

  localparam int NMASTERS_DEF = 5;
  localparam int GW_DEF       = 3;

  typedef enum logic [1:0] {
    KEEP    = 2'd0,
    RELEASE = 2'd1,
    PREEMPT = 2'd2
  } arb_dec_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/conbus_rr_pick.sv
// Round-robin picker: first set bit of req scanning upward from start,
// wrapping modulo N. Rotate, priority-encode, rotate back.
module conbus_rr_pick #(
  parameter int N  = 5,
  parameter int GW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] start,
  output logic [GW-1:0] idx,
  output logic          found
);

  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_shift;
  logic [N-1:0]   w_rot;
  logic [GW-1:0]  w_off;
  logic [GW:0]    w_sum;

  assign w_dbl   = {req, req};
  assign w_shift = w_dbl >> start;
  assign w_rot   = w_shift[N-1:0];

  always_comb begin
    w_off = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && w_rot[i]) begin
        w_off = GW'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    w_sum = {1'b0, start} + {1'b0, w_off};
    if (w_sum >= (GW+1)'(N)) w_sum = w_sum - (GW+1)'(N);
    idx = w_sum[GW-1:0];
  end

endmodule

// File: rtl/conbus_arb_quota.sv
// Round-robin conbus arbiter with per-owner transaction quota: the owner keeps
// the bus while requesting, but yields at a transaction end once over quota.
module conbus_arb_quota
  import conbus_pkg::*;
#(
  parameter int NMASTERS = NMASTERS_DEF,
  parameter int GW       = GW_DEF,
  parameter int MAX_HOLD = 16,
  parameter int CW       = 5
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [NMASTERS-1:0] req,
  input  logic                txn_end,
  output logic [GW-1:0]       gnt,
  output logic [NMASTERS-1:0] gnt_oh,
  output logic                gnt_chg,
  output logic                preempt
);

  if (GW < clog2(NMASTERS) || CW < clog2(MAX_HOLD + 1)) begin : g_bad_width
    $error("conbus_arb_quota: GW or CW too narrow");
  end

  logic [GW-1:0]       r_owner;
  logic [NMASTERS-1:0] r_oh;
  logic [CW-1:0]       r_hold;
  logic                r_chg;
  logic                r_pre;

  logic [GW-1:0]       w_start;
  logic [NMASTERS-1:0] w_others;
  logic                w_own_req;
  logic [GW-1:0]       w_rel_idx;
  logic                w_rel_found;
  logic [GW-1:0]       w_pre_idx;
  logic                w_pre_found;
  logic                w_quota;
  logic                w_count;
  arb_dec_e            w_dec;

  assign w_start   = (r_owner == GW'(NMASTERS - 1)) ? '0 : r_owner + 1'b1;
  assign w_others  = req & ~r_oh;
  assign w_own_req = |(req & r_oh);

  conbus_rr_pick #(.N(NMASTERS), .GW(GW)) u_pick_rel (
    .req   (req),
    .start (w_start),
    .idx   (w_rel_idx),
    .found (w_rel_found)
  );

  conbus_rr_pick #(.N(NMASTERS), .GW(GW)) u_pick_pre (
    .req   (w_others),
    .start (w_start),
    .idx   (w_pre_idx),
    .found (w_pre_found)
  );

  // Saturated counter keeps satisfying the quota test, so a lone owner that
  // exceeded quota is still preempted at its first contended txn_end.
  assign w_quota = (MAX_HOLD != 0) &&
                   (({1'b0, r_hold} + 1'b1) >= (CW+1)'(MAX_HOLD));
  assign w_count = (MAX_HOLD != 0) && (r_hold < CW'(MAX_HOLD));

  always_comb begin
    w_dec = KEEP;
    if (!w_own_req) begin
      if (w_rel_found) w_dec = RELEASE;
    end else if (txn_end && w_quota && w_pre_found) begin
      w_dec = PREEMPT;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_owner <= '0;
      r_oh    <= NMASTERS'(1);
      r_hold  <= '0;
      r_chg   <= 1'b0;
      r_pre   <= 1'b0;
    end else begin
      unique case (w_dec)
        RELEASE: begin
          r_owner <= w_rel_idx;
          r_oh    <= NMASTERS'(1) << w_rel_idx;
          r_hold  <= '0;
          r_chg   <= 1'b1;
          r_pre   <= 1'b0;
        end
        PREEMPT: begin
          r_owner <= w_pre_idx;
          r_oh    <= NMASTERS'(1) << w_pre_idx;
          r_hold  <= '0;
          r_chg   <= 1'b1;
          r_pre   <= 1'b1;
        end
        default: begin
          r_chg <= 1'b0;
          r_pre <= 1'b0;
          if (txn_end && w_own_req && w_count) r_hold <= r_hold + 1'b1;
        end
      endcase
    end
  end

  assign gnt     = r_owner;
  assign gnt_oh  = r_oh;
  assign gnt_chg = r_chg;
  assign preempt = r_pre;

endmodule

// File: tb/tb_conbus_arb_quota.sv
// Scoreboard bench for conbus_arb_quota: driver pushes model expectations,
// monitor pops and compares after each clock edge.
module tb_conbus_arb_quota;

  localparam int N    = 5;
  localparam int GW   = 3;
  localparam int MAXH = 4;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [N-1:0]  req     = '0;
  logic          txn_end = 1'b0;
  logic [GW-1:0] gnt;
  logic [N-1:0]  gnt_oh;
  logic          gnt_chg;
  logic          preempt;

  conbus_arb_quota #(.NMASTERS(N), .GW(GW), .MAX_HOLD(MAXH), .CW(5)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .req     (req),
    .txn_end (txn_end),
    .gnt     (gnt),
    .gnt_oh  (gnt_oh),
    .gnt_chg (gnt_chg),
    .preempt (preempt)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int gnt;
    int oh;
    int chg;
    int pre;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  int   m_owner = 0;
  int   m_hold  = 0;
  int   m_chg   = 0;
  int   m_pre   = 0;

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
  endtask

  // Reference: owner/hold model computed with plain modular scans.
  task automatic model_step(input logic [N-1:0] r, input logic t, input logic rst);
    int nxt;
    bit hit;
    m_chg = 0;
    m_pre = 0;
    if (rst) begin
      m_owner = 0;
      m_hold  = 0;
    end else if (!r[m_owner]) begin
      if (r != 0) begin
        hit = 0;
        nxt = m_owner;
        for (int k = 1; k <= N; k++) begin
          if (!hit && r[(m_owner + k) % N]) begin
            nxt = (m_owner + k) % N;
            hit = 1;
          end
        end
        m_owner = nxt;
        m_hold  = 0;
        m_chg   = 1;
      end
    end else if (t && MAXH != 0 && m_hold + 1 >= MAXH && (r & ~(N'(1) << m_owner)) != 0) begin
      hit = 0;
      nxt = m_owner;
      for (int k = 1; k < N; k++) begin
        if (!hit && r[(m_owner + k) % N]) begin
          nxt = (m_owner + k) % N;
          hit = 1;
        end
      end
      m_owner = nxt;
      m_hold  = 0;
      m_chg   = 1;
      m_pre   = 1;
    end else if (t && m_hold < MAXH) begin
      m_hold++;
    end
  endtask

  task automatic cyc(input logic [N-1:0] r, input logic t, input logic rst);
    exp_t e;
    @(negedge sys_clk);
    req     = r;
    txn_end = t;
    sys_rst = rst;
    model_step(r, t, rst);
    e.gnt = m_owner;
    e.oh  = 1 << m_owner;
    e.chg = m_chg;
    e.pre = m_pre;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge sys_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("gnt",     int'(gnt),     e.gnt);
        chk("gnt_oh",  int'(gnt_oh),  e.oh);
        chk("gnt_chg", int'(gnt_chg), e.chg);
        chk("preempt", int'(preempt), e.pre);
      end
    end
  end

  initial begin : driver
    logic [N-1:0] r;
    logic         t;
    logic         rs;
    cyc('0, 1'b0, 1'b1);
    cyc('0, 1'b0, 1'b1);
    repeat (10) cyc(5'b00000, 1'b0, 1'b0);
    // release chain 0 -> 1 -> 2 -> 4
    repeat (3) cyc(5'b10111, 1'b1, 1'b0);
    cyc(5'b10110, 1'b0, 1'b0);
    cyc(5'b10110, 1'b0, 1'b0);
    cyc(5'b10100, 1'b0, 1'b0);
    cyc(5'b10100, 1'b0, 1'b0);
    cyc(5'b10000, 1'b0, 1'b0);
    cyc(5'b10000, 1'b0, 1'b0);
    // master 2 with txn_end every 3 cycles, master 3 joins after the first
    cyc(5'b00100, 1'b0, 1'b0);
    cyc(5'b00100, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      cyc(k == 0 ? 5'b00100 : 5'b01100, 1'b0, 1'b0);
      cyc(k == 0 ? 5'b00100 : 5'b01100, 1'b0, 1'b0);
      cyc(k == 0 ? 5'b00100 : 5'b01100, 1'b1, 1'b0);
    end
    // master 1 alone past quota, then master 0 arrives between transactions
    cyc(5'b00010, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cyc(5'b00010, 1'b1, 1'b0);
      cyc(5'b00010, 1'b0, 1'b0);
    end
    repeat (3) cyc(5'b00011, 1'b0, 1'b0);
    cyc(5'b00011, 1'b1, 1'b0);
    cyc(5'b00011, 1'b0, 1'b0);
    // master 4 at quota, mid-transaction, contender waiting
    cyc(5'b10000, 1'b0, 1'b0);
    repeat (5) cyc(5'b10000, 1'b1, 1'b0);
    repeat (20) cyc(5'b10001, 1'b0, 1'b0);
    cyc(5'b10001, 1'b1, 1'b0);
    cyc(5'b00001, 1'b0, 1'b0);
    // owner 3, then reset mid-operation
    cyc(5'b01000, 1'b0, 1'b0);
    cyc(5'b01000, 1'b1, 1'b0);
    cyc(5'b01001, 1'b0, 1'b1);
    repeat (3) cyc(5'b01001, 1'b0, 1'b0);
    // randomized traffic with occasional reset
    r = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(7) == 0) r[b] = ~r[b];
      end
      t  = ($urandom_range(2) == 0);
      rs = ($urandom_range(199) == 0);
      cyc(r, t, rs);
    end
    repeat (3) @(posedge sys_clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
